// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: address/enable sequencing that turns an external dual-port RAM into a programmable delay line.
// Optional macro DELAY_LINE_CTRL_CLEAR_EN adds a CLEAR state that zeroes the RAM after reset and every reconfiguration.
module delay_line_ctrl #(
  parameter  int WIDTH         = 8,
  parameter  int DEPTH         = 256,
  parameter  int DEFAULT_DELAY = 1,
  localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [ADDR_WIDTH-1:0] cfg_delay,
  input  logic                  cfg_load,
  output logic                  busy,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [WIDTH-1:0]      ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_rd_en,
  input  logic [WIDTH-1:0]      ram_rd_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
`ifdef DELAY_LINE_CTRL_CLEAR_EN
  localparam logic [1:0] S_CLEAR   = 2'd1;
  localparam logic [1:0] S_RESTART = S_CLEAR;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
`else
  localparam logic [1:0] S_RESTART = S_RUN;
`endif
  localparam logic [ADDR_WIDTH-1:0] DELAY_RST = ADDR_WIDTH'(DEFAULT_DELAY);

  // A zero delay would read the word being written, so it is promoted to one.
  function automatic logic [ADDR_WIDTH-1:0] sat_delay(input logic [ADDR_WIDTH-1:0] d);
    return (d == '0) ? ADDR_WIDTH'(1) : d;
  endfunction

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] delay_q;
  logic                  run;
  logic                  accept;

  assign run         = (state == S_RUN);
  assign busy        = !run;
  assign in_ready    = run && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign ram_rd_en   = accept;
  assign ram_rd_addr = wr_ptr - delay_q;
  assign out_data    = ram_rd_data;

`ifdef DELAY_LINE_CTRL_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clearing;

  assign clearing    = (state == S_CLEAR);
  assign ram_wr_en   = accept || clearing;
  assign ram_wr_addr = clearing ? clr_cnt : wr_ptr;
  assign ram_wr_data = clearing ? '0 : in_data;
`else
  assign ram_wr_en   = accept;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = in_data;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      delay_q   <= DELAY_RST;
      out_valid <= 1'b0;
`ifdef DELAY_LINE_CTRL_CLEAR_EN
      clr_cnt   <= '0;
`endif
    end else begin
      if (accept)         out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;

      if (cfg_load && (state != S_IDLE)) delay_q <= sat_delay(cfg_delay);

      case (state)
        S_IDLE: state <= S_RESTART;
        S_RUN: begin
          if (accept)   wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
          if (cfg_load) state  <= S_DRAIN;
        end
        // Leave only once the last read result has been taken downstream.
        S_DRAIN: begin
          if (!out_valid) begin
            state  <= S_RESTART;
            wr_ptr <= '0;
          end
        end
`ifdef DELAY_LINE_CTRL_CLEAR_EN
        S_CLEAR: begin
          if (cfg_load) begin
            clr_cnt <= '0;
          end else if (clr_cnt == LAST_ADDR) begin
            clr_cnt <= '0;
            wr_ptr  <= '0;
            state   <= S_RUN;
          end else begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
